// File: rtl/fault_campaign_ctrl.sv
// Exhaustive single stuck-at fault campaign sequencer with valid/ready result stream.
// Optional gate-ID skip mask is enabled by defining FAULT_CAMPAIGN_MASK_EN.
//
// state  | meaning
// IDLE   | waiting for start; counters hold the last campaign totals
// APPLY  | fault (gid, val) driven for SETTLE cycles, compared on the last one
// REPORT | result record offered to the collector, fault removed
// DONE   | one-cycle completion pulse
module fault_campaign_ctrl #(
  parameter int NG     = 128,
  parameter int W      = 8,
  parameter int SETTLE = 2,
  parameter int CW     = $clog2(2*NG+1),
  localparam int GW    = (NG > 1) ? $clog2(NG) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  dut_out,
  input  logic [W-1:0]  golden_out,
`ifdef FAULT_CAMPAIGN_MASK_EN
  input  logic [NG-1:0] gid_mask,
`endif
  output logic [NG-1:0] fault_en_bus,
  output logic          fault_val,
  output logic          busy,
  output logic          done,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [GW-1:0] res_gid,
  output logic          res_val,
  output logic          res_detected,
  output logic [CW-1:0] det_cnt,
  output logic [CW-1:0] undet_cnt
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, REPORT, DONE} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gid_q, gid_d;
  logic          val_q, val_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [NG-1:0] fault_en_q, fault_en_d;
  logic          fault_val_q, fault_val_d;
  logic [GW-1:0] res_gid_q, res_gid_d;
  logic          res_val_q, res_val_d;
  logic          res_det_q, res_det_d;
  logic [CW-1:0] det_cnt_q, det_cnt_d;
  logic [CW-1:0] undet_cnt_q, undet_cnt_d;

  logic [NG-1:0] skip_start, skip_run;
  logic          first_found, next_found;
  logic [GW-1:0] first_gid, next_gid;

`ifdef FAULT_CAMPAIGN_MASK_EN
  logic [NG-1:0] mask_q, mask_d;
  assign skip_start = gid_mask;
  assign skip_run   = mask_q;
`else
  assign skip_start = '0;
  assign skip_run   = '0;
`endif

  // Descending scans leave the lowest qualifying gate ID in the result.
  always_comb begin
    first_found = 1'b0;
    first_gid   = '0;
    next_found  = 1'b0;
    next_gid    = '0;
    for (int i = NG-1; i >= 0; i--) begin
      if (!skip_start[i]) begin
        first_found = 1'b1;
        first_gid   = GW'(i);
      end
      if (!skip_run[i] && (i > int'(gid_q))) begin
        next_found = 1'b1;
        next_gid   = GW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gid_d       = gid_q;
    val_d       = val_q;
    settle_d    = settle_q;
    res_gid_d   = res_gid_q;
    res_val_d   = res_val_q;
    res_det_d   = res_det_q;
    det_cnt_d   = det_cnt_q;
    undet_cnt_d = undet_cnt_q;
`ifdef FAULT_CAMPAIGN_MASK_EN
    mask_d      = mask_q;
`endif
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            det_cnt_d   = '0;
            undet_cnt_d = '0;
            val_d       = 1'b0;
            gid_d       = first_gid;
            settle_d    = SW'(SETTLE-1);
`ifdef FAULT_CAMPAIGN_MASK_EN
            mask_d      = gid_mask;
`endif
            state_d     = first_found ? APPLY : DONE;
          end
        end
        APPLY: begin
          if (settle_q == '0) begin
            res_det_d = (dut_out != golden_out);
            res_gid_d = gid_q;
            res_val_d = val_q;
            if (dut_out != golden_out) det_cnt_d = det_cnt_q + CW'(1);
            else                       undet_cnt_d = undet_cnt_q + CW'(1);
            state_d   = REPORT;
          end else begin
            settle_d = settle_q - SW'(1);
          end
        end
        REPORT: begin
          if (res_ready) begin
            settle_d = SW'(SETTLE-1);
            if (!val_q) begin
              val_d   = 1'b1;
              state_d = APPLY;
            end else if (next_found) begin
              gid_d   = next_gid;
              val_d   = 1'b0;
              state_d = APPLY;
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Fault drive is registered from the next state so it is exact for every APPLY cycle.
    fault_en_d  = '0;
    fault_val_d = 1'b0;
    if (state_d == APPLY) begin
      fault_en_d[gid_d] = 1'b1;
      fault_val_d       = val_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gid_q       <= '0;
      val_q       <= 1'b0;
      settle_q    <= '0;
      fault_en_q  <= '0;
      fault_val_q <= 1'b0;
      res_gid_q   <= '0;
      res_val_q   <= 1'b0;
      res_det_q   <= 1'b0;
      det_cnt_q   <= '0;
      undet_cnt_q <= '0;
`ifdef FAULT_CAMPAIGN_MASK_EN
      mask_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gid_q       <= gid_d;
      val_q       <= val_d;
      settle_q    <= settle_d;
      fault_en_q  <= fault_en_d;
      fault_val_q <= fault_val_d;
      res_gid_q   <= res_gid_d;
      res_val_q   <= res_val_d;
      res_det_q   <= res_det_d;
      det_cnt_q   <= det_cnt_d;
      undet_cnt_q <= undet_cnt_d;
`ifdef FAULT_CAMPAIGN_MASK_EN
      mask_q      <= mask_d;
`endif
    end
  end

  assign fault_en_bus = fault_en_q;
  assign fault_val    = fault_val_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign res_valid    = (state_q == REPORT);
  assign res_gid      = res_gid_q;
  assign res_val      = res_val_q;
  assign res_detected = res_det_q;
  assign det_cnt      = det_cnt_q;
  assign undet_cnt    = undet_cnt_q;

endmodule
